l2_line_responder: RTL and testbench

Responder end of the instruction-cache line-fill interface: accepts a line read request (address plus read enable), fetches the 32-byte line from main memory as eight 32-bit beats, assembles the beats into a 256-bit block, and releases the requester by dropping stall for exactly one cycle with the block valid. It sits between the L1 instruction cache's L2 port and the 32-bit memory bus. It stands in for the L2 until a real L2 array exists.

---
 rtl/l2_line_responder_if.sv | 28 ++
 rtl/l2_line_responder.sv | 107 ++++++++++
 tb/tb_l2_line_responder.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/l2_line_responder_if.sv
// Line-fill port between the L1 instruction cache and the L2 stand-in,
// bundled with the 32-bit memory-side beat bus the responder drives.
interface l2_line_responder_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned LINE_W = 256;

    logic              read_en;
    logic [ADDR_W-1:0] req_addr;
    logic [LINE_W-1:0] block_out;
    logic              stall;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;
    logic [WORD_W-1:0] mem_rdata;

    // Responder side
    modport slave (
        input  read_en, req_addr, mem_ready, mem_rdata,
        output block_out, stall, mem_req, mem_addr
    );

    // Requester plus memory side
    modport master (
        output read_en, req_addr, mem_ready, mem_rdata,
        input  block_out, stall, mem_req, mem_addr
    );
endinterface

// File: rtl/l2_line_responder.sv
// Fetches a 32-byte line as eight ascending 32-bit beats and releases the
// requester with a single stall-low cycle carrying the assembled block.
module l2_line_responder (
    input  logic                clk,
    input  logic                rst_n,
    l2_line_responder_if.slave  bus
);
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned WORDS  = 8;
    localparam int unsigned BEAT_W = 3;
    localparam int unsigned LINE_W = WORDS * WORD_W;
    localparam logic [ADDR_W-1:0] LINE_MASK = 32'hFFFF_FFE0;

    typedef enum logic [1:0] {IDLE, FETCH, DONE, RELEASE} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [LINE_W-1:0]   block_q, block_d;
    logic                stall_q, stall_d;
    logic                mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [BEAT_W-1:0]   beat_nxt_c;
    logic                beat_done_c;

    assign beat_nxt_c  = BEAT_W'(beat_q + 1'b1);
    assign beat_done_c = mem_req_q && bus.mem_ready;

    // Next-state and registered-output decode
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        beat_d     = beat_q;
        block_d    = block_q;
        stall_d    = 1'b1;
        mem_req_d  = 1'b0;
        mem_addr_d = mem_addr_q;

        unique case (state_q)
            IDLE: begin
                if (bus.read_en) begin
                    base_d     = bus.req_addr & LINE_MASK;
                    beat_d     = '0;
                    mem_req_d  = 1'b1;
                    mem_addr_d = bus.req_addr & LINE_MASK;
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                // Requester withdrawal abandons the partial line
                if (!bus.read_en) begin
                    state_d = IDLE;
                end else begin
                    mem_req_d = 1'b1;
                    if (beat_done_c) begin
                        block_d[{beat_q, 5'b0} +: WORD_W] = bus.mem_rdata;
                        beat_d = beat_nxt_c;
                        if (beat_q == BEAT_W'(WORDS - 1)) begin
                            state_d   = DONE;
                            stall_d   = 1'b0;
                            mem_req_d = 1'b0;
                        end else begin
                            mem_addr_d = base_q | ADDR_W'({beat_nxt_c, 2'b00});
                        end
                    end
                end
            end
            DONE: begin
                state_d = RELEASE;
            end
            RELEASE: begin
                if (!bus.read_en) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            base_q     <= '0;
            beat_q     <= '0;
            block_q    <= '0;
            stall_q    <= 1'b1;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            beat_q     <= beat_d;
            block_q    <= block_d;
            stall_q    <= stall_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign bus.block_out = block_q;
    assign bus.stall     = stall_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_addr  = mem_addr_q;
endmodule

// File: tb/tb_l2_line_responder.sv
// Directed plus randomized line fills against a cycle-level requester/memory
// model: address sequence, stall timing, block contents, abort and reset.
module tb_l2_line_responder;
    logic clk = 1'b0;
    logic rst_n;
    logic [31:0] salt;
    int unsigned waits [8];
    int unsigned tests = 0;
    int unsigned fails = 0;

    l2_line_responder_if bus ();

    l2_line_responder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory: word at address a holds salt + word index of a
    assign bus.mem_rdata = salt + (bus.mem_addr >> 2);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Full request: cycle 0 in IDLE, beats with waits[], DONE, hold, release
    task automatic fetch_line(input logic [31:0] addr, input int unsigned hold);
        logic [31:0]  base;
        logic [255:0] exp_line;
        base = addr & 32'hFFFF_FFE0;
        for (int i = 0; i < 8; i++) exp_line[32*i +: 32] = salt + (base >> 2) + 32'(i);
        bus.req_addr  = addr;
        bus.read_en   = 1'b1;
        bus.mem_ready = 1'($urandom);
        check("req_stall", 256'(bus.stall), 256'(1'b1));
        check("req_memreq", 256'(bus.mem_req), 256'(1'b0));
        step();
        for (int b = 0; b < 8; b++) begin
            for (int w = 0; w < int'(waits[b]); w++) begin
                bus.mem_ready = 1'b0;
                bus.req_addr  = $urandom;
                check("wait_addr", 256'(bus.mem_addr), 256'(base + 32'(4 * b)));
                check("wait_memreq", 256'(bus.mem_req), 256'(1'b1));
                check("wait_stall", 256'(bus.stall), 256'(1'b1));
                step();
            end
            bus.mem_ready = 1'b1;
            bus.req_addr  = $urandom;
            check("beat_addr", 256'(bus.mem_addr), 256'(base + 32'(4 * b)));
            check("beat_memreq", 256'(bus.mem_req), 256'(1'b1));
            check("beat_stall", 256'(bus.stall), 256'(1'b1));
            step();
        end
        bus.mem_ready = 1'($urandom);
        check("done_stall", 256'(bus.stall), 256'(1'b0));
        check("done_memreq", 256'(bus.mem_req), 256'(1'b0));
        check("done_block", bus.block_out, exp_line);
        step();
        for (int h = 0; h < int'(hold); h++) begin
            check("hold_stall", 256'(bus.stall), 256'(1'b1));
            check("hold_memreq", 256'(bus.mem_req), 256'(1'b0));
            step();
        end
        bus.read_en = 1'b0;
        check("rel_stall", 256'(bus.stall), 256'(1'b1));
        check("rel_memreq", 256'(bus.mem_req), 256'(1'b0));
        step();
        check("idle_stall", 256'(bus.stall), 256'(1'b1));
        check("idle_memreq", 256'(bus.mem_req), 256'(1'b0));
        check("idle_block", bus.block_out, exp_line);
        for (int i = 0; i < 8; i++) waits[i] = 0;
    endtask

    // Request that completes only n beats; returns with beat n addressed
    task automatic partial(input logic [31:0] addr, input int unsigned n);
        logic [31:0] base;
        base = addr & 32'hFFFF_FFE0;
        bus.req_addr  = addr;
        bus.read_en   = 1'b1;
        bus.mem_ready = 1'b0;
        step();
        for (int b = 0; b < int'(n); b++) begin
            bus.mem_ready = 1'b1;
            check("part_addr", 256'(bus.mem_addr), 256'(base + 32'(4 * b)));
            step();
        end
        bus.mem_ready = 1'b0;
        check("part_memreq", 256'(bus.mem_req), 256'(1'b1));
    endtask

    initial begin
        for (int i = 0; i < 8; i++) waits[i] = 0;
        rst_n         = 1'b0;
        bus.read_en   = 1'b1;
        bus.req_addr  = 32'h0;
        bus.mem_ready = 1'b0;
        salt          = 32'h1000_0000;
        step();
        step();
        check("rst_stall", 256'(bus.stall), 256'(1'b1));
        check("rst_memreq", 256'(bus.mem_req), 256'(1'b0));
        check("rst_memaddr", 256'(bus.mem_addr), 256'(32'h0));
        check("rst_block", bus.block_out, 256'(0));

        // Fill with request already pending at reset release
        rst_n = 1'b1;
        fetch_line(32'h0, 0);
        check("fill_word0", 256'(bus.block_out[31:0]), 256'(32'h1000_0000));
        check("fill_word7", 256'(bus.block_out[255:224]), 256'(32'h1000_0007));

        // Unaligned request
        salt = $urandom;
        fetch_line(32'h0000_12F4, 0);
        check("unal_word5", 256'(bus.block_out[191:160]), 256'(salt + 32'h4BD));

        // Wait states before beats 0 and 4
        salt = $urandom;
        waits[0] = 2;
        waits[4] = 2;
        fetch_line($urandom, 0);

        // Hold-off: read_en stays high three cycles past DONE
        salt = $urandom;
        fetch_line($urandom, 3);
        step();
        check("holdoff_idle_memreq", 256'(bus.mem_req), 256'(1'b0));

        // Abort after beat 3
        salt = $urandom;
        partial($urandom, 4);
        bus.read_en = 1'b0;
        step();
        check("abort_memreq", 256'(bus.mem_req), 256'(1'b0));
        check("abort_stall", 256'(bus.stall), 256'(1'b1));
        step();
        check("abort_idle_memreq", 256'(bus.mem_req), 256'(1'b0));
        fetch_line($urandom, 0);

        // Asynchronous reset after beat 5
        salt = $urandom;
        partial($urandom, 6);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_memreq", 256'(bus.mem_req), 256'(1'b0));
        check("arst_stall", 256'(bus.stall), 256'(1'b1));
        check("arst_block", bus.block_out, 256'(0));
        step();
        rst_n = 1'b1;
        fetch_line($urandom, 0);

        // Randomized fills
        repeat (6) begin
            salt = $urandom;
            for (int i = 0; i < 8; i++) waits[i] = $urandom_range(0, 2);
            fetch_line($urandom, $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
